// File: rtl/rcu_control_fsm.sv
// rcu_control_fsm: multicycle control unit for the 16-bit RISC datapath.
// It sequences fetch, decode, execute, memory and write-back, and drives
// every enable and select of Complete_Datapath from the captured
// instruction fields and the Z/C flag registers.
// Optional build macro: RCU_RETIRE_CNT_EN adds the retire_cnt[15:0] output.
module rcu_control_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] Opcode,
  input  logic [1:0] ALU_Op,
  input  logic [2:0] Rd_Addr,
  input  logic       Z_Reg,
  input  logic       C_Reg,
  output logic       PC_CE,
  output logic       PC_Add_Src,
  output logic       PC_ALU_Sel,
  output logic       Z_CE,
  output logic       C_CE,
  output logic       Rd_Reg_CE,
  output logic       ALUOut_Reg_CE,
  output logic       RF_Write_en,
  output logic       MemW_en,
  output logic       Out_R_CE,
  output logic       Rd_Rm_Sel,
  output logic       Mem_Addr_Sel,
  output logic       MemW_Data_Sel,
  output logic [1:0] PC_Sel,
  output logic [1:0] RF_Write_Data_Sel,
  output logic [1:0] Imm_Sel,
  output logic [1:0] ALU_B_Sel,
  output logic [1:0] ALU_Control,
  output logic       busy,
  output logic       halted
`ifdef RCU_RETIRE_CNT_EN
  ,
  output logic [15:0] retire_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_PCZ, S_FETCH, S_DECODE, S_EXEC, S_MEMRD,
    S_WB, S_MEMWR, S_PCUPD, S_OUTR, S_HALT
  } state_t;

  // Instruction class, derived from opcode (and ALU_Op where it qualifies it)
  typedef enum logic [4:0] {
    K_ALU, K_ADDI, K_SUBI, K_MOV, K_LDR_I, K_LDR_R, K_STR_I, K_STR_R,
    K_CMP, K_LHI, K_LLI, K_BR, K_JMP, K_JR, K_JAL_L, K_JAL_R,
    K_OUTR, K_HLT, K_ILL
  } kind_t;

  state_t      state_reg, state_next;
  logic [4:0]  op_reg;
  logic [1:0]  alu_op_reg;
  logic [2:0]  rd_reg;
  kind_t       kind_live, kind_cap;
  logic [3:0]  cond;
  logic        taken;

  function automatic kind_t classify(input logic [4:0] op, input logic [1:0] aop);
    kind_t k;
    k = K_ILL;
    case (op)
      5'b00000: k = K_ALU;
      5'b00001: k = K_LHI;
      5'b00010: k = K_LLI;
      5'b00011: k = K_LDR_I;
      5'b00100: k = K_LDR_R;
      5'b00101: k = K_STR_I;
      5'b00110: begin
        if (aop == 2'b00)      k = K_STR_R;
        else if (aop == 2'b01) k = K_CMP;
      end
      5'b00111: k = K_ADDI;
      5'b01000: k = K_SUBI;
      5'b01011: k = K_MOV;
      5'b10000: k = K_JMP;
      5'b10001: k = K_JAL_L;
      5'b10010: k = K_JAL_R;
      5'b10011: k = K_JR;
      5'b11000, 5'b11001: k = K_BR;
      5'b11100: begin
        if (aop == 2'b00)      k = K_OUTR;
        else if (aop == 2'b01) k = K_HLT;
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // DECODE routes on the live fields (they are being captured on the same
  // edge); every later state works from the captured copy only, since the
  // instruction register is overwritten by loads.
  assign kind_live = classify(Opcode, ALU_Op);
  assign kind_cap  = classify(op_reg, alu_op_reg);

  assign Mem_Addr_Sel  = 1'b0;
  assign MemW_Data_Sel = 1'b0;

  // Branch condition from the captured opcode LSB and Rd field
  assign cond = {op_reg[0], rd_reg};
  always_comb begin
    case (cond)
      4'b0000: taken = Z_Reg;
      4'b0001: taken = ~Z_Reg;
      4'b0010: taken = C_Reg;
      4'b0011: taken = ~C_Reg;
      4'b1110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // State register and instruction-field capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      alu_op_reg <= '0;
      rd_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg     <= Opcode;
        alu_op_reg <= ALU_Op;
        rd_reg     <= Rd_Addr;
      end
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_next        = state_reg;
    PC_CE             = 1'b0;
    PC_Add_Src        = 1'b0;
    PC_ALU_Sel        = 1'b0;
    Z_CE              = 1'b0;
    C_CE              = 1'b0;
    Rd_Reg_CE         = 1'b0;
    ALUOut_Reg_CE     = 1'b0;
    RF_Write_en       = 1'b0;
    MemW_en           = 1'b0;
    Out_R_CE          = 1'b0;
    Rd_Rm_Sel         = 1'b0;
    PC_Sel            = 2'b00;
    RF_Write_Data_Sel = 2'b00;
    Imm_Sel           = 2'b00;
    ALU_B_Sel         = 2'b00;
    ALU_Control       = 2'b00;
    busy              = (state_reg != S_IDLE) && (state_reg != S_HALT);
    halted            = (state_reg == S_HALT);
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_PCZ;
      end
      S_PCZ: begin
        PC_Sel     = 2'b11;
        PC_CE      = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        PC_ALU_Sel = 1'b0;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        Rd_Reg_CE = 1'b1;
        PC_CE     = 1'b1;
        case (kind_live)
          K_ALU, K_ADDI, K_SUBI, K_MOV, K_LDR_I, K_LDR_R,
          K_STR_I, K_STR_R, K_CMP:      state_next = S_EXEC;
          K_LHI, K_LLI, K_JAL_L, K_JAL_R: state_next = S_WB;
          K_BR, K_JMP, K_JR:            state_next = S_PCUPD;
          K_OUTR:                       state_next = S_OUTR;
          K_HLT:                        state_next = S_HALT;
          default: state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC: begin
        ALUOut_Reg_CE = 1'b1;
        Rd_Rm_Sel     = 1'b1;
        state_next    = S_WB;
        case (kind_cap)
          K_ALU: begin
            ALU_Control = alu_op_reg;
            Z_CE = 1'b1;
            C_CE = 1'b1;
          end
          K_ADDI: begin
            ALU_B_Sel = 2'b01;
            Z_CE = 1'b1;
            C_CE = 1'b1;
          end
          K_SUBI: begin
            ALU_B_Sel   = 2'b01;
            ALU_Control = 2'b10;
            Z_CE = 1'b1;
            C_CE = 1'b1;
          end
          K_MOV:   ALU_B_Sel = 2'b10;
          K_LDR_I: begin
            ALU_B_Sel  = 2'b01;
            state_next = S_MEMRD;
          end
          K_LDR_R: state_next = S_MEMRD;
          K_STR_I: begin
            ALU_B_Sel  = 2'b01;
            state_next = S_MEMWR;
          end
          K_STR_R: state_next = S_MEMWR;
          K_CMP: begin
            ALU_Control = 2'b10;
            Z_CE = 1'b1;
            C_CE = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        PC_ALU_Sel = 1'b1;
        state_next = S_WB;
      end
      S_MEMWR: begin
        PC_ALU_Sel = 1'b1;
        MemW_en    = 1'b1;
        state_next = S_FETCH;
      end
      S_WB: begin
        RF_Write_en = 1'b1;
        state_next  = S_FETCH;
        case (kind_cap)
          K_LHI: begin
            RF_Write_Data_Sel = 2'b01;
            Imm_Sel = 2'b11;
          end
          K_LLI: begin
            RF_Write_Data_Sel = 2'b01;
            Imm_Sel = 2'b10;
          end
          K_JAL_L, K_JAL_R: begin
            RF_Write_Data_Sel = 2'b11;
            state_next = S_PCUPD;
          end
          K_LDR_I, K_LDR_R: RF_Write_Data_Sel = 2'b00;
          default: RF_Write_Data_Sel = 2'b10;
        endcase
      end
      S_PCUPD: begin
        state_next = S_FETCH;
        case (kind_cap)
          K_BR: begin
            if (taken) begin
              PC_Add_Src = 1'b1;
              Imm_Sel    = 2'b01;
              PC_CE      = 1'b1;
            end
          end
          K_JAL_L: begin
            PC_Add_Src = 1'b1;
            Imm_Sel    = 2'b01;
            PC_CE      = 1'b1;
          end
          K_JMP: begin
            PC_Sel = 2'b01;
            PC_CE  = 1'b1;
          end
          K_JR: begin
            PC_Sel = 2'b10;
            PC_CE  = 1'b1;
          end
          K_JAL_R: begin
            PC_Sel    = 2'b10;
            Rd_Rm_Sel = 1'b1;
            PC_CE     = 1'b1;
          end
          default: PC_CE = 1'b0;
        endcase
      end
      S_OUTR: begin
        Rd_Rm_Sel  = 1'b1;
        Out_R_CE   = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef RCU_RETIRE_CNT_EN
  logic [15:0] retire_cnt_reg;
  logic        retire;

  // An instruction retires on the cycle that hands control back to FETCH
  // (or enters HALT); PCZ also goes to FETCH but is not an instruction.
  assign retire = (state_reg != S_PCZ) && (state_reg != S_HALT) &&
                  (state_reg != S_IDLE) &&
                  ((state_next == S_FETCH) || (state_next == S_HALT));

  // Retired-instruction counter, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst || (state_reg == S_PCZ)) retire_cnt_reg <= '0;
    else if (retire)                 retire_cnt_reg <= retire_cnt_reg + 16'd1;
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_rcu_control_fsm.sv
// Testbench for rcu_control_fsm: table of instructions with hand-computed
// per-cycle control words, plus hand sequences for reset abort and HALT.
module tb_rcu_control_fsm;

  typedef logic [24:0] obs_t;

  logic       clk, rst, start;
  logic [4:0] Opcode;
  logic [1:0] ALU_Op;
  logic [2:0] Rd_Addr;
  logic       Z_Reg, C_Reg;
  logic       PC_CE, PC_Add_Src, PC_ALU_Sel, Z_CE, C_CE, Rd_Reg_CE;
  logic       ALUOut_Reg_CE, RF_Write_en, MemW_en, Out_R_CE, Rd_Rm_Sel;
  logic       Mem_Addr_Sel, MemW_Data_Sel;
  logic [1:0] PC_Sel, RF_Write_Data_Sel, Imm_Sel, ALU_B_Sel, ALU_Control;
  logic       busy, halted;
`ifdef RCU_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  rcu_control_fsm dut (
    .clk(clk), .rst(rst), .start(start),
    .Opcode(Opcode), .ALU_Op(ALU_Op), .Rd_Addr(Rd_Addr),
    .Z_Reg(Z_Reg), .C_Reg(C_Reg),
    .PC_CE(PC_CE), .PC_Add_Src(PC_Add_Src), .PC_ALU_Sel(PC_ALU_Sel),
    .Z_CE(Z_CE), .C_CE(C_CE), .Rd_Reg_CE(Rd_Reg_CE),
    .ALUOut_Reg_CE(ALUOut_Reg_CE), .RF_Write_en(RF_Write_en),
    .MemW_en(MemW_en), .Out_R_CE(Out_R_CE), .Rd_Rm_Sel(Rd_Rm_Sel),
    .Mem_Addr_Sel(Mem_Addr_Sel), .MemW_Data_Sel(MemW_Data_Sel),
    .PC_Sel(PC_Sel), .RF_Write_Data_Sel(RF_Write_Data_Sel),
    .Imm_Sel(Imm_Sel), .ALU_B_Sel(ALU_B_Sel), .ALU_Control(ALU_Control),
    .busy(busy), .halted(halted)
`ifdef RCU_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs packed into one word, PC_CE at bit 0
  obs_t obs;
  assign obs = {ALU_Control, ALU_B_Sel, Imm_Sel, RF_Write_Data_Sel, PC_Sel,
                halted, busy, MemW_Data_Sel, Mem_Addr_Sel, Rd_Rm_Sel,
                Out_R_CE, MemW_en, RF_Write_en, ALUOut_Reg_CE, Rd_Reg_CE,
                C_CE, Z_CE, PC_ALU_Sel, PC_Add_Src, PC_CE};

  localparam obs_t PCCE   = 25'd1 << 0;
  localparam obs_t PCADD  = 25'd1 << 1;
  localparam obs_t PCALU  = 25'd1 << 2;
  localparam obs_t ZCE    = 25'd1 << 3;
  localparam obs_t CCE    = 25'd1 << 4;
  localparam obs_t RDREG  = 25'd1 << 5;
  localparam obs_t ALUOUT = 25'd1 << 6;
  localparam obs_t RFWE   = 25'd1 << 7;
  localparam obs_t MEMW   = 25'd1 << 8;
  localparam obs_t OUTR   = 25'd1 << 9;
  localparam obs_t RDRM   = 25'd1 << 10;
  localparam obs_t BUSY   = 25'd1 << 13;
  localparam obs_t HALTED = 25'd1 << 14;

  function automatic obs_t pcsel(input logic [1:0] v); return obs_t'(v) << 15; endfunction
  function automatic obs_t wdsel(input logic [1:0] v); return obs_t'(v) << 17; endfunction
  function automatic obs_t imms (input logic [1:0] v); return obs_t'(v) << 19; endfunction
  function automatic obs_t bsel (input logic [1:0] v); return obs_t'(v) << 21; endfunction
  function automatic obs_t aluc (input logic [1:0] v); return obs_t'(v) << 23; endfunction

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [1:0] aop;
    logic [2:0] rd;
    logic       z;
    logic       c;
    int         n;      // cycles from FETCH through the last instruction cycle
    obs_t       e2;     // expected words after FETCH and DECODE
    obs_t       e3;
    obs_t       e4;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic [4:0] op, input logic [1:0] aop,
                     input logic [2:0] rd, input logic z, input logic c, input int n,
                     input obs_t e2, input obs_t e3, input obs_t e4);
    vec_t v;
    v.name = nm; v.op = op; v.aop = aop; v.rd = rd; v.z = z; v.c = c;
    v.n = n; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    vecs.push_back(v);
  endtask

  localparam obs_t FETCHW = BUSY;
  localparam obs_t DECW   = BUSY | RDREG | PCCE;
  localparam obs_t EXB    = BUSY | ALUOUT | RDRM;
  localparam obs_t TAKEN  = BUSY | PCCE | PCADD;

  initial begin
    obs_t exp_w;
    int   retired;
    rst = 1'b1; start = 1'b0;
    Opcode = '0; ALU_Op = '0; Rd_Addr = '0; Z_Reg = 1'b0; C_Reg = 1'b0;

    // Stimulus table: {name, Opcode, ALU_Op, Rd_Addr, Z, C, cycles, words}
    add("adc",     5'b00000, 2'b01, 3'b010, 0, 0, 4, EXB | ZCE | CCE | aluc(2'b01), BUSY | RFWE | wdsel(2'b10), 0);
    add("sbb",     5'b00000, 2'b11, 3'b001, 0, 0, 4, EXB | ZCE | CCE | aluc(2'b11), BUSY | RFWE | wdsel(2'b10), 0);
    add("addi",    5'b00111, 2'b10, 3'b011, 0, 0, 4, EXB | ZCE | CCE | bsel(2'b01), BUSY | RFWE | wdsel(2'b10), 0);
    add("subi",    5'b01000, 2'b00, 3'b011, 0, 0, 4, EXB | ZCE | CCE | bsel(2'b01) | aluc(2'b10), BUSY | RFWE | wdsel(2'b10), 0);
    add("mov",     5'b01011, 2'b00, 3'b100, 0, 0, 4, EXB | bsel(2'b10), BUSY | RFWE | wdsel(2'b10), 0);
    add("ldr",     5'b00011, 2'b00, 3'b101, 0, 0, 5, EXB | bsel(2'b01) | imms(2'b00), BUSY | PCALU, BUSY | RFWE | wdsel(2'b00));
    add("str_imm", 5'b00101, 2'b10, 3'b001, 0, 0, 4, EXB | bsel(2'b01), BUSY | PCALU | MEMW, 0);
    add("str_reg", 5'b00110, 2'b00, 3'b001, 0, 0, 4, EXB, BUSY | PCALU | MEMW, 0);
    add("cmp",     5'b00110, 2'b01, 3'b010, 0, 0, 3, EXB | ZCE | CCE | aluc(2'b10), 0, 0);
    add("lhi",     5'b00001, 2'b11, 3'b011, 0, 0, 3, BUSY | RFWE | wdsel(2'b01) | imms(2'b11), 0, 0);
    add("lli",     5'b00010, 2'b10, 3'b011, 0, 0, 3, BUSY | RFWE | wdsel(2'b01) | imms(2'b10), 0, 0);
    add("beq_t",   5'b11000, 2'b00, 3'b000, 1, 0, 3, TAKEN | imms(2'b01), 0, 0);
    add("beq_nt",  5'b11000, 2'b00, 3'b000, 0, 1, 3, BUSY, 0, 0);
    add("bne_t",   5'b11000, 2'b00, 3'b001, 0, 0, 3, TAKEN | imms(2'b01), 0, 0);
    add("bcs_t",   5'b11000, 2'b00, 3'b010, 0, 1, 3, TAKEN | imms(2'b01), 0, 0);
    add("bcc_t",   5'b11000, 2'b00, 3'b011, 0, 0, 3, TAKEN | imms(2'b01), 0, 0);
    add("bcc_nt",  5'b11000, 2'b00, 3'b011, 0, 1, 3, BUSY, 0, 0);
    add("bal",     5'b11001, 2'b00, 3'b110, 0, 0, 3, TAKEN | imms(2'b01), 0, 0);
    add("c1000_nt",5'b11001, 2'b00, 3'b000, 1, 1, 3, BUSY, 0, 0);
    add("jmp",     5'b10000, 2'b00, 3'b000, 0, 0, 3, BUSY | PCCE | pcsel(2'b01), 0, 0);
    add("jr",      5'b10011, 2'b00, 3'b010, 0, 0, 3, BUSY | PCCE | pcsel(2'b10), 0, 0);
    add("jal_lbl", 5'b10001, 2'b00, 3'b111, 0, 0, 4, BUSY | RFWE | wdsel(2'b11), TAKEN | imms(2'b01), 0);
    add("jal_reg", 5'b10010, 2'b00, 3'b111, 0, 0, 4, BUSY | RFWE | wdsel(2'b11), BUSY | PCCE | pcsel(2'b10) | RDRM, 0);
    add("outr",    5'b11100, 2'b00, 3'b001, 0, 0, 3, BUSY | RDRM | OUTR, 0, 0);
    add("illegal", 5'b11111, 2'b00, 3'b000, 0, 0, 2, 0, 0, 0);
    add("ill_0110",5'b00110, 2'b10, 3'b000, 0, 0, 2, 0, 0, 0);

    // Reset, then start
    step(); step();
    check("reset_idle", obs, 25'd0);
    rst = 1'b0; start = 1'b1;
    step();
    check("pcz", obs, BUSY | PCCE | pcsel(2'b11));
    start = 1'b0;
    step();

    // Table: enter each vector in FETCH, hold fields until DECODE has
    // captured them, then drive garbage to prove the captured copy is used.
    retired = 0;
    foreach (vecs[i]) begin
      Opcode = vecs[i].op; ALU_Op = vecs[i].aop; Rd_Addr = vecs[i].rd;
      Z_Reg = vecs[i].z; C_Reg = vecs[i].c;
      for (int k = 0; k < vecs[i].n; k++) begin
        if (k > 0) step();
        if (k == 2) begin
          Opcode = 5'b11111; ALU_Op = 2'b11; Rd_Addr = 3'b111;
        end
        case (k)
          0: exp_w = FETCHW;
          1: exp_w = DECW;
          2: exp_w = vecs[i].e2;
          3: exp_w = vecs[i].e3;
          default: exp_w = vecs[i].e4;
        endcase
        check($sformatf("%s_c%0d", vecs[i].name, k), obs, exp_w);
      end
      step();
      retired++;
    end
    check("back_to_fetch", obs, FETCHW);
`ifdef RCU_RETIRE_CNT_EN
    check("retire_cnt", obs_t'(retire_cnt), obs_t'(retired));
`endif

    // Reset in the middle of an ADD's EXEC: no write-back follows
    Opcode = 5'b00000; ALU_Op = 2'b00; Rd_Addr = 3'b001;
    step();
    check("abort_decode", obs, DECW);
    step();
    check("abort_exec", obs, EXB | ZCE | CCE);
    rst = 1'b1;
    step();
    check("abort_idle", obs, 25'd0);
    rst = 1'b0;
    step();
    check("abort_no_wb", obs, 25'd0);

    // rst wins over start
    rst = 1'b1; start = 1'b1;
    step();
    check("rst_over_start", obs, 25'd0);
    rst = 1'b0;
    step();
    check("restart_pcz", obs, BUSY | PCCE | pcsel(2'b11));
    start = 1'b0;
    step();
    check("restart_fetch", obs, FETCHW);

    // HALT: held for 10 cycles with start asserted, released only by rst
    Opcode = 5'b11100; ALU_Op = 2'b01; Rd_Addr = 3'b000;
    step();
    check("halt_decode", obs, DECW);
    step();
    Opcode = 5'b00000; ALU_Op = 2'b00;
    start = 1'b1;
    check("halt_entry", obs, HALTED);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("halt_hold%0d", k), obs, HALTED);
    end
    start = 1'b0; rst = 1'b1;
    step();
    check("halt_rst", obs, 25'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
